// File: rtl/status_uart_tx.sv
// Status UART transmitter: serialises one byte per request as 8N1, or 8E1 when STATUS_UART_TX_PARITY_EN is defined.
// Latency: start bit appears on TxD the cycle after acceptance; tx_done pulses on the first IDLE cycle after STOP.
// Backpressure: a request is taken only in IDLE (including the tx_done cycle); tx_start is ignored while tx_busy is high.
module status_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       TxD,
    output logic       tx_busy,
    output logic       tx_done
);

    // Baud counter spans 0..CLKS_PER_BIT-1; keep at least one bit for the degenerate width case.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef STATUS_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t          state_q;
    logic [CW-1:0]   baud_q;
    logic [CW-1:0]   baud_d;
    logic            baud_wrap_d;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            txd_q;
    logic            busy_q;
    logic            done_q;
`ifdef STATUS_UART_TX_PARITY_EN
    logic            parity_q;
`endif

    // Baud timing: the last cycle of every bit is the one where the counter sits at CLKS_PER_BIT-1.
    always_comb begin
        baud_wrap_d = (baud_q == BAUD_LAST);
        baud_d      = baud_wrap_d ? '0 : baud_q + CW'(1);
    end

    // Frame sequencer; every output is produced by this register stage so TxD is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef STATUS_UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            // tx_done is a single-cycle strobe; only the STOP->IDLE step raises it.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                    baud_q <= '0;
                    if (tx_start) begin
                        // Byte is captured here only; later tx_data changes cannot reach the line.
                        shift_q   <= tx_data;
                        bit_idx_q <= 3'd0;
`ifdef STATUS_UART_TX_PARITY_EN
                        parity_q  <= ^tx_data;
`endif
                        state_q   <= START;
                        txd_q     <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                START: begin
                    baud_q <= baud_d;
                    if (baud_wrap_d) begin
                        state_q <= DATA;
                        txd_q   <= shift_q[0];
                    end
                end

                DATA: begin
                    baud_q <= baud_d;
                    if (baud_wrap_d) begin
                        if (bit_idx_q == 3'd7) begin
`ifdef STATUS_UART_TX_PARITY_EN
                            state_q <= PARITY;
                            txd_q   <= parity_q;
`else
                            state_q <= STOP;
                            txd_q   <= 1'b1;
`endif
                        end else begin
                            // Shift toward bit 0 and present the next bit in the same edge.
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            txd_q     <= shift_q[1];
                        end
                    end
                end

`ifdef STATUS_UART_TX_PARITY_EN
                PARITY: begin
                    baud_q <= baud_d;
                    if (baud_wrap_d) begin
                        state_q <= STOP;
                        txd_q   <= 1'b1;
                    end
                end
`endif

                STOP: begin
                    baud_q <= baud_d;
                    if (baud_wrap_d) begin
                        // Returning to IDLE here lets a request be taken in the tx_done cycle.
                        state_q <= IDLE;
                        txd_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    baud_q  <= '0;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TxD     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: doc/status_uart_tx.md
STATUS_UART_TX -- requirements
Module: status_uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: tx_start  input  1  request to send tx_data; sampled each clk edge.
REQ-005 SHALL have port: tx_data  input  8  byte to send; sampled only on the accepting edge.
REQ-006 SHALL have port: TxD  output  1  serial line, idle high, LSB first.
REQ-007 SHALL have port: tx_busy  output  1  high while a frame is in progress.
REQ-008 SHALL have port: tx_done  output  1  one-cycle pulse at frame end.
REQ-009 SHALL use one clock (clk) and a synchronous, active-high reset (reset).

Function
REQ-010 SHALL implement FSM states IDLE, START, DATA, PARITY (only with macro), STOP; all outputs registered.
REQ-011 SHALL accept a request when state=IDLE and tx_start=1 on the same edge: latch tx_data into a shift register and enter START.
REQ-012 SHALL ignore tx_start while not in IDLE; the in-flight frame and latched byte are unaffected.
REQ-013 SHALL drive TxD low for exactly CLKS_PER_BIT cycles in START, starting the cycle after acceptance (latency 1 cycle).
REQ-014 SHALL, in DATA, send bits 0..7 LSB first, each held exactly CLKS_PER_BIT cycles, using a 3-bit bit index and a baud counter of width clog2(CLKS_PER_BIT).
REQ-015 SHALL drive TxD high for exactly CLKS_PER_BIT cycles in STOP, then return to IDLE.
REQ-016 SHALL assert tx_busy from the cycle after acceptance through the last STOP cycle; tx_busy=0 in IDLE.
REQ-017 SHALL pulse tx_done for exactly one cycle on the first IDLE cycle after STOP; tx_busy=0 in that cycle.
REQ-018 SHALL accept tx_start in the tx_done cycle (back-to-back), giving no idle gap beyond that cycle; frame period = 10*CLKS_PER_BIT+1 cycles (11*CLKS_PER_BIT+1 with parity).
REQ-019 SHALL hold TxD high in IDLE regardless of tx_data changes.
REQ-020 SHALL wrap the baud counter to 0 at CLKS_PER_BIT-1; no bit may be shortened or lengthened by a new request or by tx_data changes mid-frame.

Reset
REQ-021 SHALL, on reset=1 at a clk edge, set state=IDLE, TxD=1, tx_busy=0, tx_done=0, counters and shift register=0.
REQ-022 SHALL abort any frame on reset mid-operation: TxD high from the next edge, no tx_done pulse for the aborted frame.
REQ-023 SHALL give reset priority over tx_start in the same cycle (request dropped).

Configuration
REQ-024 SHALL compile an even-parity bit when macro STATUS_UART_TX_PARITY_EN is defined: PARITY state between DATA and STOP, TxD = XOR of the 8 data bits, for CLKS_PER_BIT cycles (8E1).
REQ-025 SHALL, without STATUS_UART_TX_PARITY_EN, omit the PARITY state and its logic entirely (8N1).

Verification (CLKS_PER_BIT=4)
REQ-026 SHALL cover: reset, tx_start=1 with tx_data=0xA5 -> TxD per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; tx_busy high 40 cycles; tx_done one pulse at cycle 41.
REQ-027 SHALL cover: with STOP... PARITY_EN defined, send 0x07 -> bits 0,1,1,1,0,0,0,0,0,1(parity),1; send 0xA5 -> parity bit 0.
REQ-028 SHALL cover: tx_start=1 with 0x3C held during frame of 0x55 -> 0x3C never transmitted; exactly one tx_done.
REQ-029 SHALL cover: tx_start asserted in tx_done cycle with 0xFF after 0x00 -> second start bit begins next cycle; both frames bit-exact.
REQ-030 SHALL cover: reset asserted at cycle 15 of a 0x81 frame -> TxD=1, tx_busy=0 from next edge, no tx_done; subsequent 0x81 frame correct.
REQ-031 SHALL cover: reset and tx_start both high in one cycle -> no frame starts, TxD stays 1.
